// File: rtl/booth_divider_iter_if.sv
// Operand/result handshake bundle for the iterative divider.
// Master drives operands and out_ready; slave returns in_ready and the result.
interface booth_divider_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, in_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, in_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/booth_divider_iter.sv
// Radix-2 restoring divider, one quotient bit per clock; result WIDTH+1 edges after accept.
// Result held in DONE until out_ready; in_ready is low for the whole operation.
module booth_divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_divider_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, step, fixup, retire;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, qd, dsr, q_out, r_out;
  logic             neg_q, neg_r, dbz;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;

  assign a_neg  = bus.in_signed & bus.dividend[WIDTH-1];
  assign b_neg  = bus.in_signed & bus.divisor[WIDTH-1];
  assign a_mag  = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag  = b_neg ? -bus.divisor  : bus.divisor;
  assign b_zero = (bus.divisor == '0);

  // qd shifts dividend bits out of the top while quotient bits enter at the bottom
  assign rem_sh = {rem, qd[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    fixup     = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH)) begin
          fixup     = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem   <= '0;
      qd    <= '0;
      dsr   <= '0;
      q_out <= '0;
      r_out <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      if (accept) begin
        if (b_zero) begin
          q_out <= '1;
          r_out <= bus.dividend;
          dbz   <= 1'b1;
        end else begin
          qd    <= a_mag;
          dsr   <= b_mag;
          rem   <= '0;
          cnt   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end
      if (step) begin
        cnt <= cnt + CW'(1);
        qd  <= {qd[WIDTH-2:0], ~diff[WIDTH]};
        // a negative trial keeps the shifted value, whose top bit is then always clear
        rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      end
      if (fixup) begin
        q_out <= neg_q ? -qd  : qd;
        r_out <= neg_r ? -rem : rem;
      end
      if (retire) dbz <= 1'b0;
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dbz;
endmodule
